draw_arbiter: RTL and testbench
===============================

// Module: draw_arbiter
// PURPOSE
//  Shares the single sprite draw engine between the game's draw/erase requesters
//  (garbage draw, garbage erase on hit, press erase, press draw). Accepts one request
//  at a time, drives the engine's item/erase/position fields and holds them for the
//  engine's fixed completion time, then signals completion to the requester.
//  Sits between the game control FSMs and the draw engine.
// PARAMETERS
//  NUM_REQ      4     number of requester channels; index 0..NUM_REQ-1
//  POS_W        3     position field width
//  NUM_POS      7     legal positions 0..NUM_POS-1
//  GARB_CYCLES  402   engine occupancy for item=0 (garbage sprite)
//  PRESS_CYCLES 2402  engine occupancy for item=1 (press sprite)
//  CNT_W        12    wait counter width; must hold max(GARB_CYCLES,PRESS_CYCLES)
// PORTS
//  CLOCK_50    in   1              system clock, 50 MHz
//  reset_n     in   1              synchronous active-low reset
//  req         in   NUM_REQ        request level per channel
//  req_item    in   NUM_REQ        0=garbage, 1=press
//  req_erase   in   NUM_REQ        1=erase, 0=draw
//  req_pos     in   NUM_REQ*POS_W  position; channel i at [i*POS_W +: POS_W]
//  gnt         out  NUM_REQ        one-hot, 1-cycle pulse: request accepted, fields latched
//  done        out  NUM_REQ        one-hot, 1-cycle pulse: operation complete
//  busy        out  1              high in every state except IDLE
//  bad_pos     out  1              sticky: a request with pos >= NUM_POS was accepted
//  draw_item   out  1              to engine: item select
//  draw_erase  out  1              to engine: erase select
//  draw_pos    out  POS_W          to engine: position
//  draw_start  out  1              to engine: 1-cycle start pulse
// BEHAVIOUR
//  Reset: state=IDLE; gnt, done, busy, bad_pos, draw_item, draw_erase, draw_pos,
//   draw_start, counter and owner all 0. Reset mid-operation aborts: no done issued.
//  Handshake: requester raises req with fields stable; holds until its gnt pulse.
//   Fields sampled only on the grant cycle. req high after done = new request.
//  FSM (all outputs registered):
//   IDLE : if |req: pick winner w, gnt[w]<=1, latch item/erase/pos, owner<=w -> START.
//          else stay; draw_* hold last values.
//   START: if latched pos < NUM_POS: draw_start<=1 (exactly 1 cycle); counter<=0 -> WAIT.
//          if pos >= NUM_POS: no draw_start, bad_pos<=1 -> DONE directly.
//   WAIT : counter+1 each cycle; when counter == DUR-1 -> DONE.
//          DUR = item ? PRESS_CYCLES : GARB_CYCLES. draw_* stable throughout.
//   DONE : done[owner]<=1 for 1 cycle -> IDLE.
//  Latency: req seen cycle N -> gnt at N+1 -> draw_start at N+2 -> done at N+3+DUR.
//   Bad-pos request: gnt N+1, done N+3. Next grant no earlier than cycle after done.
//  Requests arriving while busy wait (not lost while req held); no queueing beyond req.
//  Simultaneous reqs: exactly one gnt per arbitration; losers keep waiting.
//  Counter never wraps: DUR <= 2^CNT_W guaranteed by parameter choice.
//  bad_pos clears only on reset.
// CONFIGURATION
//  ROUND_ROBIN_EN defined: winner = first asserted req at index > last owner, wrapping
//   modulo NUM_REQ; last owner reset value NUM_REQ-1 (so channel 0 first after reset).
//  ROUND_ROBIN_EN undefined: fixed priority, lowest asserted index wins.
// TESTING
//  1. reset, req=0001 item=0 erase=0 pos=2 -> gnt=0001 next cycle, draw_start 1 cycle
//     later with draw_pos=2, done[0] exactly 403 cycles after draw_start.
//  2. req=0010 item=1 erase=1 pos=6 -> draw_erase=1, draw_pos=6 held stable,
//     done[1] 2403 cycles after draw_start; busy low the cycle after done.
//  3. req=1111 held, fixed priority -> grant order 0,0,0...(channel 0 starves others);
//     with ROUND_ROBIN_EN -> grant order 0,1,2,3,0.
//  4. req=0100 pos=7 -> gnt[2], no draw_start, bad_pos=1 sticky, done[2] 2 cycles after gnt.
//  5. reset_n low 100 cycles into WAIT -> next cycle all outputs 0, no done; new req
//     after reset served normally.
//  6. req[3] asserted during another channel's WAIT -> gnt[3] only after that done.

Source files
------------

// File: rtl/draw_arbiter.sv
// Shares the sprite draw engine between draw/erase requesters; one operation at a time.
// Define ROUND_ROBIN_EN for round-robin arbitration; default build uses fixed priority (lowest index wins).
module draw_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int POS_W        = 3,
   parameter int NUM_POS      = 7,
   parameter int GARB_CYCLES  = 402,
   parameter int PRESS_CYCLES = 2402,
   parameter int CNT_W        = 12
) (
   input  logic                     CLOCK_50,
   input  logic                     reset_n,
   input  logic [NUM_REQ-1:0]       i_req,
   input  logic [NUM_REQ-1:0]       i_req_item,
   input  logic [NUM_REQ-1:0]       i_req_erase,
   input  logic [NUM_REQ*POS_W-1:0] i_req_pos,
   output logic [NUM_REQ-1:0]       o_gnt,
   output logic [NUM_REQ-1:0]       o_done,
   output logic                     o_busy,
   output logic                     o_bad_pos,
   output logic                     o_draw_item,
   output logic                     o_draw_erase,
   output logic [POS_W-1:0]         o_draw_pos,
   output logic                     o_draw_start,
   output logic [1:0]               o_state
);

   // Handshake: a requester holds i_req with stable fields until its one-cycle o_gnt;
   // fields are sampled only on the grant edge, and o_done pulses once when the engine is free.

   localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [CNT_W-1:0] GARB_LAST  = CNT_W'(GARB_CYCLES - 1);
   localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

   state_t              r_state, w_state;
   logic [NUM_REQ-1:0]  r_gnt, w_gnt, r_done, w_done;
   logic                r_busy, w_busy, r_bad_pos, w_bad_pos;
   logic                r_item, w_item, r_erase, w_erase, r_start, w_start;
   logic [POS_W-1:0]    r_pos, w_pos, w_pos_sel;
   logic [CNT_W-1:0]    r_cnt, w_cnt, w_cnt_last;
   logic [OWN_W-1:0]    r_owner, w_owner, w_win;
   logic                w_pos_ok;
`ifdef ROUND_ROBIN_EN
   logic [OWN_W-1:0]    r_last, w_last;
`endif

   // Later loop iterations overwrite earlier ones, so the final hit is the winner.
   always_comb begin
      logic [OWN_W-1:0] idx;
      idx   = '0;
      w_win = '0;
`ifdef ROUND_ROBIN_EN
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = OWN_W'((int'(r_last) + k) % NUM_REQ);
         if (i_req[idx]) w_win = idx;
      end
`else
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = OWN_W'(k);
         if (i_req[idx]) w_win = idx;
      end
`endif
   end

   assign w_pos_sel  = i_req_pos[int'(w_win)*POS_W +: POS_W];
   assign w_cnt_last = r_item ? PRESS_LAST : GARB_LAST;
   assign w_pos_ok   = ({1'b0, r_pos} < (POS_W+1)'(NUM_POS));

   always_comb begin
      w_state   = r_state;
      w_gnt     = '0;
      w_done    = '0;
      w_start   = 1'b0;
      w_bad_pos = r_bad_pos;
      w_item    = r_item;
      w_erase   = r_erase;
      w_pos     = r_pos;
      w_cnt     = r_cnt;
      w_owner   = r_owner;
`ifdef ROUND_ROBIN_EN
      w_last    = r_last;
`endif
      case (r_state)
         S_IDLE: begin
            if (|i_req) begin
               w_gnt   = NUM_REQ'(1) << w_win;
               w_item  = i_req_item[w_win];
               w_erase = i_req_erase[w_win];
               w_pos   = w_pos_sel;
               w_owner = w_win;
`ifdef ROUND_ROBIN_EN
               w_last  = w_win;
`endif
               w_state = S_START;
            end
         end
         S_START: begin
            // An out-of-range position never reaches the engine.
            if (w_pos_ok) begin
               w_start = 1'b1;
               w_cnt   = '0;
               w_state = S_WAIT;
            end else begin
               w_bad_pos = 1'b1;
               w_state   = S_DONE;
            end
         end
         S_WAIT: begin
            if (r_cnt == w_cnt_last) w_state = S_DONE;
            else                     w_cnt   = r_cnt + CNT_W'(1);
         end
         S_DONE: begin
            w_done  = NUM_REQ'(1) << r_owner;
            w_state = S_IDLE;
         end
         default: w_state = S_IDLE;
      endcase
      w_busy = (w_state != S_IDLE);
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_gnt     <= '0;
         r_done    <= '0;
         r_busy    <= 1'b0;
         r_bad_pos <= 1'b0;
         r_item    <= 1'b0;
         r_erase   <= 1'b0;
         r_pos     <= '0;
         r_start   <= 1'b0;
         r_cnt     <= '0;
         r_owner   <= '0;
`ifdef ROUND_ROBIN_EN
         r_last    <= OWN_W'(NUM_REQ - 1);
`endif
      end else begin
         r_state   <= w_state;
         r_gnt     <= w_gnt;
         r_done    <= w_done;
         r_busy    <= w_busy;
         r_bad_pos <= w_bad_pos;
         r_item    <= w_item;
         r_erase   <= w_erase;
         r_pos     <= w_pos;
         r_start   <= w_start;
         r_cnt     <= w_cnt;
         r_owner   <= w_owner;
`ifdef ROUND_ROBIN_EN
         r_last    <= w_last;
`endif
      end
   end

   assign o_gnt        = r_gnt;
   assign o_done       = r_done;
   assign o_busy       = r_busy;
   assign o_bad_pos    = r_bad_pos;
   assign o_draw_item  = r_item;
   assign o_draw_erase = r_erase;
   assign o_draw_pos   = r_pos;
   assign o_draw_start = r_start;
   assign o_state      = r_state;

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed bench for draw_arbiter: grant/start/done timing, field hold, bad position,
// mid-operation reset, arbitration order under contention and requests arriving while busy.
module tb_draw_arbiter;

   logic        CLOCK_50 = 1'b0;
   logic        reset_n  = 1'b0;
   logic [3:0]  req      = '0;
   logic [3:0]  item     = '0;
   logic [3:0]  erase    = '0;
   logic [11:0] pos      = '0;
   logic [3:0]  o_gnt, o_done;
   logic        o_busy, o_bad_pos, o_draw_item, o_draw_erase, o_draw_start;
   logic [2:0]  o_draw_pos;
   logic [1:0]  o_state;

   int n_cmp = 0;
   int n_err = 0;

   draw_arbiter dut (
      .CLOCK_50     (CLOCK_50),
      .reset_n      (reset_n),
      .i_req        (req),
      .i_req_item   (item),
      .i_req_erase  (erase),
      .i_req_pos    (pos),
      .o_gnt        (o_gnt),
      .o_done       (o_done),
      .o_busy       (o_busy),
      .o_bad_pos    (o_bad_pos),
      .o_draw_item  (o_draw_item),
      .o_draw_erase (o_draw_erase),
      .o_draw_pos   (o_draw_pos),
      .o_draw_start (o_draw_start),
      .o_state      (o_state)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int ch, input logic it, input logic er, input logic [2:0] p);
      item[ch]          = it;
      erase[ch]         = er;
      pos[ch*3 +: 3]    = p;
      req[ch]           = 1'b1;
   endtask

   // sel: 0=gnt 1=draw_start 2=done. n = negedges until seen, -1 if budget expires.
   task automatic wait_ev(input int sel, input int budget, output int n, output logic [3:0] v);
      n = -1;
      v = '0;
      for (int i = 1; i <= budget; i++) begin
         @(negedge CLOCK_50);
         if (sel == 0 && o_gnt != 0)       begin n = i; v = o_gnt;        break; end
         if (sel == 1 && o_draw_start)     begin n = i; v = 4'b0001;      break; end
         if (sel == 2 && o_done != 0)      begin n = i; v = o_done;       break; end
      end
   endtask

   // One complete draw/erase on a single channel; exp_gap = draw_start to done in cycles.
   task automatic run_op(input string tag, input int ch, input logic it, input logic er,
                         input logic [2:0] p, input int exp_gap);
      int         n;
      logic [3:0] v;
      int         bad;
      bad = 0;
      set_req(ch, it, er, p);
      wait_ev(0, 5, n, v);
      chk({tag, "_gnt"}, {28'd0, v}, 32'(1 << ch));
      chk({tag, "_gnt_lat"}, n, 1);
      req[ch] = 1'b0;
      @(negedge CLOCK_50);
      chk({tag, "_start"}, {31'd0, o_draw_start}, 1);
      chk({tag, "_fields"}, {28'd0, o_draw_item, o_draw_erase, o_draw_pos}, {28'd0, it, er, p});
      n = -1;
      v = '0;
      for (int i = 1; i <= exp_gap + 50; i++) begin
         @(negedge CLOCK_50);
         if (o_draw_pos != p || o_draw_erase != er || o_draw_item != it || o_draw_start) bad++;
         if (o_done != 0) begin n = i; v = o_done; break; end
         if (!o_busy) bad++;
      end
      chk({tag, "_hold"}, bad, 0);
      chk({tag, "_done_gap"}, n, exp_gap);
      chk({tag, "_done"}, {28'd0, v}, 32'(1 << ch));
      chk({tag, "_busy_at_done"}, {31'd0, o_busy}, 0);
      @(negedge CLOCK_50);
      chk({tag, "_idle_after"}, {27'd0, o_busy, o_done}, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, {14'd0, o_gnt, o_done, o_busy, o_bad_pos, o_draw_item, o_draw_erase,
                o_draw_pos, o_draw_start, o_state}, 0);
   endtask

   initial begin
      int         n, gnt_at, done_at;
      int         t_prev, t_now;
      logic [3:0] v, gv;
      logic [3:0] exp_seq [5];
`ifdef ROUND_ROBIN_EN
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
      exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif

      // Reset state
      reset_n = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      chk_all_zero("reset_state");
      reset_n = 1'b1;
      @(negedge CLOCK_50);

      // Garbage draw on ch0 and press erase on ch1
      run_op("t1", 0, 1'b0, 1'b0, 3'd2, 403);
      run_op("t2", 1, 1'b1, 1'b1, 3'd6, 2403);

      // Out-of-range position: no engine start, sticky flag, fast done
      set_req(2, 1'b0, 1'b0, 3'd7);
      wait_ev(0, 5, n, v);
      chk("t4_gnt", {28'd0, v}, 4);
      req[2] = 1'b0;
      @(negedge CLOCK_50);
      chk("t4_no_start1", {31'd0, o_draw_start}, 0);
      chk("t4_bad_pos", {31'd0, o_bad_pos}, 1);
      @(negedge CLOCK_50);
      chk("t4_done", {27'd0, o_draw_start, o_done}, 4);
      run_op("t4_next", 1, 1'b0, 1'b1, 3'd0, 403);
      chk("t4_sticky", {31'd0, o_bad_pos}, 1);

      // Reset 100 cycles into WAIT aborts without done
      set_req(0, 1'b1, 1'b0, 3'd3);
      wait_ev(0, 5, n, v);
      req[0] = 1'b0;
      wait_ev(1, 3, n, v);
      chk("t5_start_lat", n, 1);
      repeat (100) @(negedge CLOCK_50);
      reset_n = 1'b0;
      @(negedge CLOCK_50);
      chk_all_zero("t5_reset_mid");
      @(negedge CLOCK_50);
      reset_n = 1'b1;
      wait_ev(2, 2600, n, v);
      chk("t5_no_done", n, -1);
      run_op("t5_after", 3, 1'b0, 1'b0, 3'd5, 403);

      // Fresh reset, then all four requesting continuously
      reset_n = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      reset_n = 1'b1;
      for (int ch = 0; ch < 4; ch++) set_req(ch, 1'b0, 1'b0, 3'(ch + 1));
      t_prev = 0;
      for (int g = 0; g < 5; g++) begin
         wait_ev(0, 500, n, v);
         chk($sformatf("t3_gnt%0d", g), {28'd0, v}, {28'd0, exp_seq[g]});
         if (g > 0) chk($sformatf("t3_spacing%0d", g), n, 405);
         t_now = t_prev + n;
         t_prev = t_now;
      end
      req = '0;
      wait_ev(2, 500, n, v);
      chk("t3_last_done", {28'd0, v}, {28'd0, exp_seq[4]});

      // ch3 arrives while ch0 is in WAIT: granted only after ch0's done
      set_req(0, 1'b0, 1'b0, 3'd1);
      wait_ev(0, 5, n, v);
      chk("t6_gnt0", {28'd0, v}, 1);
      req[0] = 1'b0;
      repeat (50) @(negedge CLOCK_50);
      set_req(3, 1'b0, 1'b1, 3'd4);
      gnt_at  = -1;
      done_at = -1;
      gv      = '0;
      for (int i = 1; i <= 600; i++) begin
         @(negedge CLOCK_50);
         if (o_done != 0) done_at = i;
         if (o_gnt != 0) begin gnt_at = i; gv = o_gnt; break; end
      end
      chk("t6_gnt3", {28'd0, gv}, 8);
      chk("t6_done_seen", {31'd0, done_at > 0}, 1);
      chk("t6_gnt_after_done", gnt_at, done_at + 1);
      req[3] = 1'b0;
      @(negedge CLOCK_50);
      chk("t6_fields", {28'd0, o_draw_item, o_draw_erase, o_draw_pos}, {28'd0, 1'b0, 1'b1, 3'd4});
      wait_ev(2, 500, n, v);
      chk("t6_done3", {28'd0, v}, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
